adder_share_arbiter: RTL and testbench

Sequential controller that shares one 16-bit adder datapath (17-bit sum, unsigned or signed operands) between four requesters. Each requester raises a request with its two operands; the block arbitrates, latches the winner's operands, performs the add in a registered stage and returns the sum with a one-cycle done pulse tagged with the winner's index. It sits between the problem-set operand sources and the shared adder so that only one adder instance exists in the design.

---
 rtl/adder_share_arbiter.sv | 159 +++++++++++++++
 tb/tb_adder_share_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
// Shares one 16-bit adder (17-bit sum) between four requesters.
// Sequence per operation: IDLE (arbitrate, latch operands) -> EXEC (add)
// -> RESP (done pulse, count) -> IDLE.
// Configuration macro: RR_FAIRNESS_EN
//   defined   : round-robin arbitration with a 2-bit pointer
//   undefined : fixed priority, lowest set request index wins
// Parameters: SIGNED_INPUT (0 = zero-extend, 1 = sign-extend operands),
//             OP_COUNT_W (width of the completed-operation counter).
//
// Requester handshake: a requester raises req[i] together with its operand
// slices and holds both stable until it sees done with done_id == i, then
// drops req[i] in the cycle after done. Requests and operands are sampled
// only while the FSM is in IDLE; a request still high when the FSM returns
// to IDLE counts as a new request. Dropping req during EXEC or RESP does not
// cancel the operation already granted.

module adder_share_arbiter #(
   parameter int SIGNED_INPUT = 0,
   parameter int OP_COUNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            req,
   input  logic [63:0]           op_a,
   input  logic [63:0]           op_b,
   output logic                  busy,
   output logic                  grant_valid,
   output logic [1:0]            grant_id,
   output logic                  done,
   output logic [1:0]            done_id,
   output logic [16:0]           result,
   output logic [OP_COUNT_W-1:0] op_count,
   output logic [1:0]            fsm_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state;
   logic [15:0] a_reg;
   logic [15:0] b_reg;
   logic [1:0]  winner;

   // Winner chosen from the live request vector (only used in IDLE)
   logic [1:0]  sel_id;
   logic [15:0] sel_a;
   logic [15:0] sel_b;

   // Extend a 16-bit operand to 17 bits so the sum can never overflow
   function automatic logic [16:0] ext17(input logic [15:0] v);
      if (SIGNED_INPUT != 0) begin
         ext17 = {v[15], v};
      end else begin
         ext17 = {1'b0, v};
      end
   endfunction

`ifdef RR_FAIRNESS_EN
   // Round-robin pointer: the requester that gets first look next time
   logic [1:0] rr_ptr;

   // Round-robin pick: first set request scanning rr_ptr, rr_ptr+1, ... mod 4
   always_comb begin
      logic       found;
      logic [1:0] idx;
      sel_id = 2'd0;
      found  = 1'b0;
      idx    = 2'd0;
      for (int k = 0; k < 4; k++) begin
         idx = rr_ptr + 2'(k);
         if (!found && req[idx]) begin
            sel_id = idx;
            found  = 1'b1;
         end
      end
   end
`else
   // Fixed-priority pick: lowest set request index wins
   always_comb begin
      sel_id = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (req[k]) begin
            sel_id = 2'(k);
         end
      end
   end
`endif

   // Operand slices belonging to the selected requester
   always_comb begin
      sel_a = op_a[{sel_id, 4'b0000} +: 16];
      sel_b = op_b[{sel_id, 4'b0000} +: 16];
   end

   // Main controller: state, operand capture, add, and all registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         a_reg       <= 16'd0;
         b_reg       <= 16'd0;
         winner      <= 2'd0;
         busy        <= 1'b0;
         grant_valid <= 1'b0;
         grant_id    <= 2'd0;
         done        <= 1'b0;
         done_id     <= 2'd0;
         result      <= 17'd0;
         op_count    <= '0;
`ifdef RR_FAIRNESS_EN
         rr_ptr      <= 2'd0;
`endif
      end else begin
         // done is a single-cycle pulse; only the EXEC branch raises it
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (|req) begin
                  a_reg       <= sel_a;
                  b_reg       <= sel_b;
                  winner      <= sel_id;
                  busy        <= 1'b1;
                  grant_valid <= 1'b1;
                  grant_id    <= sel_id;
                  state       <= EXEC;
               end
            end
            EXEC: begin
               result  <= ext17(a_reg) + ext17(b_reg);
               done    <= 1'b1;
               done_id <= winner;
               state   <= RESP;
            end
            RESP: begin
               op_count    <= op_count + OP_COUNT_W'(1);
               busy        <= 1'b0;
               grant_valid <= 1'b0;
               grant_id    <= 2'd0;
`ifdef RR_FAIRNESS_EN
               rr_ptr      <= winner + 2'd1;
`endif
               state       <= IDLE;
            end
            default: begin
               busy        <= 1'b0;
               grant_valid <= 1'b0;
               grant_id    <= 2'd0;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign fsm_state = state;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed testbench for adder_share_arbiter.
// Three instances share the same stimulus: default parameters, a signed
// variant, and a variant with a 2-bit operation counter.

module tb_adder_share_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req;
   logic [63:0] op_a;
   logic [63:0] op_b;

   logic        busy, grant_valid, done;
   logic [1:0]  grant_id, done_id, fsm_state;
   logic [16:0] result;
   logic [15:0] op_count;

   logic        s_busy, s_grant_valid, s_done;
   logic [1:0]  s_grant_id, s_done_id, s_fsm_state;
   logic [16:0] s_result;
   logic [15:0] s_op_count;

   logic        w_busy, w_grant_valid, w_done;
   logic [1:0]  w_grant_id, w_done_id, w_fsm_state;
   logic [16:0] w_result;
   logic [1:0]  w_op_count;

   int checks   = 0;
   int failures = 0;

   adder_share_arbiter #(.SIGNED_INPUT(0), .OP_COUNT_W(16)) dut (
      .clk(clk), .reset(reset), .req(req), .op_a(op_a), .op_b(op_b),
      .busy(busy), .grant_valid(grant_valid), .grant_id(grant_id),
      .done(done), .done_id(done_id), .result(result),
      .op_count(op_count), .fsm_state(fsm_state));

   adder_share_arbiter #(.SIGNED_INPUT(1), .OP_COUNT_W(16)) dut_s (
      .clk(clk), .reset(reset), .req(req), .op_a(op_a), .op_b(op_b),
      .busy(s_busy), .grant_valid(s_grant_valid), .grant_id(s_grant_id),
      .done(s_done), .done_id(s_done_id), .result(s_result),
      .op_count(s_op_count), .fsm_state(s_fsm_state));

   adder_share_arbiter #(.SIGNED_INPUT(0), .OP_COUNT_W(2)) dut_w (
      .clk(clk), .reset(reset), .req(req), .op_a(op_a), .op_b(op_b),
      .busy(w_busy), .grant_valid(w_grant_valid), .grant_id(w_grant_id),
      .done(w_done), .done_id(w_done_id), .result(w_result),
      .op_count(w_op_count), .fsm_state(w_fsm_state));

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input int idx, input logic [15:0] a, input logic [15:0] b);
      op_a[16*idx +: 16] = a;
      op_b[16*idx +: 16] = b;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req   = 4'b0000;
      op_a  = '0;
      op_b  = '0;
      tick();
      tick();
      checks++;
      if (busy !== 1'b0 || grant_valid !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctrl: busy=%b grant_valid=%b done=%b, required 0 0 0", busy, grant_valid, done);
      end
      checks++;
      if (grant_id !== 2'd0 || done_id !== 2'd0 || result !== 17'd0 || op_count !== 16'd0) begin
         failures++;
         $display("FAIL reset_data: grant_id=%0d done_id=%0d result=%h op_count=%0d, required 0 0 0 0",
                  grant_id, done_id, result, op_count);
      end
      reset = 1'b0;
   endtask

   task automatic test_single();
      req = 4'b0100;
      set_ops(2, 16'd456, 16'd123);
      tick();
      checks++;
      if (grant_valid !== 1'b1 || grant_id !== 2'd2 || busy !== 1'b1 || done !== 1'b0) begin
         failures++;
         $display("FAIL single_exec: gv=%b gid=%0d busy=%b done=%b, required 1 2 1 0",
                  grant_valid, grant_id, busy, done);
      end
      tick();
      checks++;
      if (done !== 1'b1 || done_id !== 2'd2 || result !== 17'd579) begin
         failures++;
         $display("FAIL single_resp: done=%b done_id=%0d result=%0d, required 1 2 579", done, done_id, result);
      end
      req = 4'b0000;
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || op_count !== 16'd1 || result !== 17'd579) begin
         failures++;
         $display("FAIL single_after: done=%b busy=%b op_count=%0d result=%0d, required 0 0 1 579",
                  done, busy, op_count, result);
      end
   endtask

   task automatic test_signed();
      req = 4'b0001;
      set_ops(0, 16'hFFFF, 16'h0001);
      tick();
      tick();
      checks++;
      if (done !== 1'b1 || result !== 17'h10000) begin
         failures++;
         $display("FAIL unsigned_sum: done=%b result=%h, required 1 10000", done, result);
      end
      checks++;
      if (s_done !== 1'b1 || s_result !== 17'h00000) begin
         failures++;
         $display("FAIL signed_sum: done=%b result=%h, required 1 00000", s_done, s_result);
      end
      req = 4'b0000;
      tick();
      checks++;
      if (op_count !== 16'd2 || w_op_count !== 2'd2) begin
         failures++;
         $display("FAIL count_two: op_count=%0d w_op_count=%0d, required 2 2", op_count, w_op_count);
      end
   endtask

   task automatic test_early_drop();
      req = 4'b0010;
      set_ops(1, 16'd5, 16'd127);
      tick();
      req = 4'b0000;
      set_ops(1, 16'd999, 16'd999);
      tick();
      checks++;
      if (done !== 1'b1 || done_id !== 2'd1 || result !== 17'd132) begin
         failures++;
         $display("FAIL early_drop: done=%b done_id=%0d result=%0d, required 1 1 132", done, done_id, result);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || fsm_state !== 2'd0) begin
         failures++;
         $display("FAIL early_drop_idle: busy=%b state=%0d, required 0 0", busy, fsm_state);
      end
   endtask

   task automatic test_contention();
      int exp_ids[5];
      logic [1:0] exp_wrap[5];
      int n;
      int last_cyc;
      bit pend;
`ifdef RR_FAIRNESS_EN
      exp_ids = '{0, 1, 2, 3, 0};
`else
      exp_ids = '{0, 0, 0, 0, 0};
`endif
      exp_wrap = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      // Fresh reset so the pointer starts at 0
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) set_ops(i, 16'(i * 10 + 1), 16'd100);
      req = 4'b1111;
      n = 0;
      last_cyc = -1;
      pend = 1'b0;
      for (int c = 0; c < 40 && !(n == 5 && !pend); c++) begin
         tick();
         if (pend) begin
            checks++;
            if (w_op_count !== exp_wrap[n-1] || op_count !== 16'(n)) begin
               failures++;
               $display("FAIL count_wrap[%0d]: w_op_count=%0d op_count=%0d, required %0d %0d",
                        n - 1, w_op_count, op_count, exp_wrap[n-1], n);
            end
            pend = 1'b0;
         end
         if (done) begin
            checks++;
            if (done_id !== 2'(exp_ids[n]) || result !== 17'(exp_ids[n] * 10 + 101)) begin
               failures++;
               $display("FAIL contention[%0d]: done_id=%0d result=%0d, required %0d %0d",
                        n, done_id, result, exp_ids[n], exp_ids[n] * 10 + 101);
            end
            if (last_cyc >= 0) begin
               checks++;
               if (c - last_cyc != 3) begin
                  failures++;
                  $display("FAIL done_spacing[%0d]: gap=%0d, required 3", n, c - last_cyc);
               end
            end
            last_cyc = c;
            n++;
            pend = 1'b1;
            if (n == 5) req = 4'b0000;
         end
      end
      checks++;
      if (n != 5 || pend) begin
         failures++;
         $display("FAIL contention_timeout: dones=%0d, required 5", n);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      // Serve requester 2 alone so a round-robin pointer would move to 3
      req = 4'b0100;
      set_ops(2, 16'd40, 16'd2);
      tick();
      tick();
      req = 4'b0000;
      tick();
      // Contested request, then reset while in EXEC
      req = 4'b1001;
      set_ops(0, 16'd1000, 16'd24);
      set_ops(3, 16'd7, 16'd8);
      tick();
      checks++;
      if (grant_valid !== 1'b1 || fsm_state !== 2'd1) begin
         failures++;
         $display("FAIL mid_exec: gv=%b state=%0d, required 1 1", grant_valid, fsm_state);
      end
      reset = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 17'd0 || op_count !== 16'd0 || grant_valid !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset: busy=%b done=%b result=%0d op_count=%0d gv=%b, required 0 0 0 0 0",
                  busy, done, result, op_count, grant_valid);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (grant_valid !== 1'b1 || grant_id !== 2'd0 || done !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_grant: gv=%b gid=%0d done=%b, required 1 0 0", grant_valid, grant_id, done);
      end
      tick();
      checks++;
      if (done !== 1'b1 || done_id !== 2'd0 || result !== 17'd1024) begin
         failures++;
         $display("FAIL post_reset_done: done=%b done_id=%0d result=%0d, required 1 0 1024", done, done_id, result);
      end
      req = 4'b0000;
      tick();
      checks++;
      if (done !== 1'b0 || op_count !== 16'd1) begin
         failures++;
         $display("FAIL post_reset_count: done=%b op_count=%0d, required 0 1", done, op_count);
      end
   endtask

   initial begin
      reset = 1'b1;
      req   = 4'b0000;
      op_a  = '0;
      op_b  = '0;
      test_reset();
      test_single();
      test_signed();
      test_early_drop();
      test_contention();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
